// File: rtl/program_counter_pkg.sv
// program_counter_pkg
// Shared constants and types for the CPU program counter and for any other
// CPU block that needs to carry an instruction address.
//   PC_WIDTH        register and bus width in bits
//   PC_RESET_VALUE  address forced while reset is asserted
//   pc_word_t       one instruction address
package program_counter_pkg;

  localparam int PC_WIDTH = 16;

  typedef logic [PC_WIDTH-1:0] pc_word_t;

  localparam pc_word_t PC_RESET_VALUE = '0;

endpackage

// File: rtl/program_counter_if.sv
// program_counter_if
// Microcode control lines and the visible register contents of the program
// counter. The shared data bus is a true tri-state net and stays a plain
// inout port on the program counter itself.
//   load_bar  active-low load strobe (capture bus on next rising clk)
//   en_bar    active-low output enable (drive value onto bus)
//   inc       active-high increment strobe
//   value     current counter contents
// Modports: master = microcode decoder side, slave = program counter side.
interface program_counter_if
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) ();

  logic             load_bar;
  logic             en_bar;
  logic             inc;
  logic [WIDTH-1:0] value;

  modport master (
    output load_bar,
    output en_bar,
    output inc,
    input  value
  );

  modport slave (
    input  load_bar,
    input  en_bar,
    input  inc,
    output value
  );

endinterface

// File: rtl/program_counter_incrementer.sv
// pc_incrementer
// Combinational WIDTH-bit +1 adder. The carry out is discarded, so the
// all-ones word wraps to zero.
//   a  operand
//   y  a + 1 modulo 2^WIDTH
module pc_incrementer
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign y = a + ONE;

endmodule

// File: rtl/program_counter.sv
// program_counter
// 16-bit CPU program counter on the shared tri-state data bus. Holds the
// address of the next instruction; it can be loaded from the bus, incremented,
// and can drive its contents back onto the bus.
//   clk    system clock, all state changes on the rising edge except reset
//   reset  asynchronous, active-high; forces RESET_VALUE
//   bus    shared tri-state data bus: sampled on load, driven when en_bar=0
//   ctl    control lines and value output (program_counter_if.slave)
// Rising-edge priority: load (load_bar=0) over increment (inc=1) over hold.
// Optional macro PC_ASSERT_EN compiles in simulation-only checks for unknown
// control levels and for the pointless load-while-driving combination.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = PC_RESET_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] bus,
  program_counter_if.slave ctl
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_inc;

  pc_incrementer #(.WIDTH(WIDTH)) u_incrementer (
    .a (value_q),
    .y (value_inc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= RESET_VALUE;
    end else if (!ctl.load_bar) begin
      value_q <= bus;
    end else if (ctl.inc) begin
      value_q <= value_inc;
    end
  end

  assign ctl.value = value_q;

  // No register stage: a change of value while enabled reaches the bus at once.
  assign bus = ctl.en_bar ? {WIDTH{1'bz}} : value_q;

`ifdef PC_ASSERT_EN
  a_ctl_known : assert property (
    @(posedge clk) disable iff (reset)
    !$isunknown({ctl.load_bar, ctl.en_bar, ctl.inc})
  ) else $error("program_counter: X/Z on load_bar/en_bar/inc");

  // Loading while driving just re-captures the current value.
  a_load_while_driving : assert property (
    @(posedge clk) disable iff (reset)
    !(!ctl.load_bar && !ctl.en_bar)
  ) else $warning("program_counter: load_bar and en_bar both low");
`endif

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;
  import program_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        drv_en = 1'b0;
  logic [15:0] drv_val = 16'd0;
  wire  [15:0] bus;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;

  program_counter_if pif ();

  assign bus = drv_en ? drv_val : 16'bz;

  program_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ctl   (pif)
  );

  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // load a word through the bus at the next rising edge; caller checks it
  task automatic drive_load(input logic [15:0] v);
    @(negedge clk);
    #1;
    drv_en = 1'b1;
    drv_val = v;
    pif.load_bar = 1'b0;
    pif.inc = 1'b0;
    exp_q.push_back(v);
    tick();
    pif.load_bar = 1'b1;
    drv_en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    reset = 1'b1;
    exp_q.push_back(16'd0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL reset_async: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    // other inputs ignored while reset held
    drv_en = 1'b1;
    drv_val = 16'd1234;
    pif.load_bar = 1'b0;
    pif.inc = 1'b1;
    exp_q.push_back(16'd0);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL reset_hold: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    @(negedge clk);
    pif.load_bar = 1'b1;
    pif.inc = 1'b0;
    drv_en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_load();
    drive_load(16'd1500);
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL load: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    pif.inc = 1'b1;
    exp_q.push_back(16'd1501);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL inc: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    pif.inc = 1'b0;
    exp_q.push_back(16'd1501);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL hold: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
  endtask

  task automatic test_edge_sensitivity();
    // inc pulse entirely inside the low phase
    @(negedge clk);
    #1 pif.inc = 1'b1;
    #1 pif.inc = 1'b0;
    exp_q.push_back(16'd1501);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL inc_pulse_between_edges: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    // inc high only across a falling edge
    #1 pif.inc = 1'b1;
    @(negedge clk);
    #1 pif.inc = 1'b0;
    exp_q.push_back(16'd1501);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL inc_across_falling_edge: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    // load requested mid-cycle must not act before the rising edge
    drive_load(16'd65535);
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL load_ffff: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    @(negedge clk);
    #1;
    drv_en = 1'b1;
    drv_val = 16'd100;
    pif.load_bar = 1'b0;
    exp_q.push_back(16'd65535);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL load_before_edge: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    exp_q.push_back(16'd100);
    tick();
    pif.load_bar = 1'b1;
    drv_en = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL load_at_edge: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
  endtask

  task automatic test_wrap();
    drive_load(16'd65535);
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL wrap_load: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    pif.inc = 1'b1;
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd1);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL wrap: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    tick();
    pif.inc = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL after_wrap: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
  endtask

  task automatic test_bus_drive();
    drive_load(16'd6502);
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL bus_load: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    pif.en_bar = 1'b0;
    exp_q.push_back(16'd6502);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (bus !== exp) begin
      $display("FAIL bus_drive: bus=%0d expected=%0d", bus, exp);
      errors++;
    end
    // increment while enabled reaches the bus in the same cycle
    @(negedge clk);
    pif.inc = 1'b1;
    exp_q.push_back(16'd6503);
    tick();
    pif.inc = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (bus !== exp) begin
      $display("FAIL bus_follows_value: bus=%0d expected=%0d", bus, exp);
      errors++;
    end
    @(negedge clk);
    pif.en_bar = 1'b1;
    drv_en = 1'b1;
    drv_val = 16'd2056;
    exp_q.push_back(16'd2056);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (bus !== exp) begin
      $display("FAIL bus_release: bus=%0d expected=%0d", bus, exp);
      errors++;
    end
    exp_q.push_back(16'd6503);
    tick();
    drv_en = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL value_while_released: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
  endtask

  task automatic test_priority();
    drive_load(16'd10);
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL prio_setup: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    @(negedge clk);
    drv_en = 1'b1;
    drv_val = 16'd42;
    pif.load_bar = 1'b0;
    pif.inc = 1'b1;
    exp_q.push_back(16'd42);
    tick();
    pif.load_bar = 1'b1;
    pif.inc = 1'b0;
    drv_en = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL load_over_inc: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
  endtask

  task automatic test_load_while_driving();
    @(negedge clk);
    pif.en_bar = 1'b0;
    pif.load_bar = 1'b0;
    exp_q.push_back(16'd42);
    tick();
    tick();
    pif.load_bar = 1'b1;
    pif.en_bar = 1'b1;
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL load_while_driving: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
  endtask

  task automatic test_reset_again();
    drive_load(16'd1501);
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL reset2_setup: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    @(negedge clk);
    #1 reset = 1'b1;
    exp_q.push_back(16'd0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL reset_from_1501: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    pif.inc = 1'b1;
    exp_q.push_back(16'd1);
    tick();
    pif.inc = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (pif.value !== exp) begin
      $display("FAIL resume_after_reset: value=%0d expected=%0d", pif.value, exp);
      errors++;
    end
  endtask

  initial begin
    pif.load_bar = 1'b1;
    pif.en_bar = 1'b1;
    pif.inc = 1'b0;
    test_reset();
    test_load();
    test_edge_sensitivity();
    test_wrap();
    test_bus_drive();
    test_priority();
    test_load_while_driving();
    test_reset_again();
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
      errors++;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: time=%0t expected=finish", $time);
    $fatal(1);
  end

endmodule
